// File: rtl/thermal_pkg.sv
// Shared types and constants for the room thermal plant model.
// The state enum doubles as the externally visible mode encoding.
package thermal_pkg;

  localparam int TEMP_W = 5;
  localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;
  localparam logic [TEMP_W-1:0] TEMP_MIN = 5'd0;
  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // A divide ratio of 256 encodes as 0; the divider's terminal count
  // (div - 1, modulo 256) then lands on 255 as required.
  function automatic logic [DIV_W-1:0] div_code(input int div);
    return DIV_W'(div);
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Free-running modulo-div counter with a restart input; tick marks the
// terminal count and is suppressed on a restart cycle.
module rate_divider
  import thermal_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic             terminal;

  assign terminal = (count == div - DIV_W'(1));
  assign tick     = terminal && !restart;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || terminal) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/room_thermal_model.sv
// Plant model: temperature ramps while heating/cooling, drifts to ambient
// when idle, and freezes in a latched FAULT when both commands collide.
module room_thermal_model
  import thermal_pkg::*;
#(
  parameter int RESET_TEMP = 18,
  parameter int AMBIENT    = 22,
  parameter int HEAT_DIV   = 4,
  parameter int COOL_DIV   = 4,
  parameter int DRIFT_DIV  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              heating,
  input  logic              cooling,
  input  logic              load,
  input  logic [TEMP_W-1:0] load_value,
  input  logic              fault_clr,
  output logic [TEMP_W-1:0] temperature,
  output logic [1:0]        mode,
  output logic              fault
);

  localparam logic [TEMP_W-1:0] RESET_T   = TEMP_W'(RESET_TEMP);
  localparam logic [TEMP_W-1:0] AMBIENT_T = TEMP_W'(AMBIENT);
  localparam logic [DIV_W-1:0]  HEAT_CODE  = div_code(HEAT_DIV);
  localparam logic [DIV_W-1:0]  COOL_CODE  = div_code(COOL_DIV);
  localparam logic [DIV_W-1:0]  DRIFT_CODE = div_code(DRIFT_DIV);

  state_t            state;
  state_t            next_state;
  logic              both;
  logic              restart;
  logic              tick;
  logic [DIV_W-1:0]  div_sel;
  logic [TEMP_W-1:0] temp_next;

  assign both = heating && cooling;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = IDLE;
    if (state == FAULT && !(fault_clr && !both)) begin
      next_state = FAULT;
    end else if (both) begin
      next_state = FAULT;
    end else if (heating) begin
      next_state = HEAT;
    end else if (cooling) begin
      next_state = COOL;
    end
  end

  always_comb begin
    div_sel = DRIFT_CODE;
    case (state)
      HEAT:    div_sel = HEAT_CODE;
      COOL:    div_sel = COOL_CODE;
      default: div_sel = DRIFT_CODE;
    endcase
  end

  // FAULT keeps the divider parked at zero; any transition or load drops
  // the partial count so the first step is always a full period away.
  assign restart = load || (next_state != state) || (state == FAULT);

  rate_divider u_rate_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .div     (div_sel),
    .tick    (tick)
  );

  always_comb begin
    temp_next = temperature;
    if (load) begin
      temp_next = load_value;
    end else if (tick) begin
      case (state)
        HEAT: if (temperature != TEMP_MAX) temp_next = temperature + TEMP_W'(1);
        COOL: if (temperature != TEMP_MIN) temp_next = temperature - TEMP_W'(1);
        IDLE: begin
          if (temperature < AMBIENT_T) begin
            temp_next = temperature + TEMP_W'(1);
          end else if (temperature > AMBIENT_T) begin
            temp_next = temperature - TEMP_W'(1);
          end
        end
        default: temp_next = temperature;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      temperature <= RESET_T;
    end else begin
      state       <= next_state;
      temperature <= temp_next;
    end
  end

  assign mode  = state;
  assign fault = (state == FAULT);

endmodule

// File: tb/tb_room_thermal_model.sv
// Directed bench for room_thermal_model with default parameters; expected
// values are hand-computed from the step/latency rules.
module tb_room_thermal_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       heating;
  logic       cooling;
  logic       load;
  logic [4:0] load_value;
  logic       fault_clr;
  logic [4:0] temperature;
  logic [1:0] mode;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  room_thermal_model dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .heating     (heating),
    .cooling     (cooling),
    .load        (load),
    .load_value  (load_value),
    .fault_clr   (fault_clr),
    .temperature (temperature),
    .mode        (mode),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int t, input int m, input int f);
    check({tag, "_temp"},  int'(temperature), t);
    check({tag, "_mode"},  int'(mode),        m);
    check({tag, "_fault"}, int'(fault),       f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; heating = 1'b0; cooling = 1'b0;
    load = 1'b0; load_value = 5'd0; fault_clr = 1'b0;

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1 check_state("reset_async", 18, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Idle drift from 18 toward 22
    tick(15); check_state("idle_c15", 18, 0, 0);
    tick(1);  check("idle_c16", int'(temperature), 19);
    tick(48); check("idle_c64", int'(temperature), 22);
    tick(32); check("idle_c96", int'(temperature), 22);

    // Idle drift downward from 26
    load = 1'b1; load_value = 5'd26; tick(1); load = 1'b0;
    check("load26", int'(temperature), 26);
    tick(15); check("drift_dn_c15", int'(temperature), 26);
    tick(1);  check("drift_dn_c16", int'(temperature), 25);

    // Heating ramp from 18
    load = 1'b1; load_value = 5'd18; tick(1); load = 1'b0;
    heating = 1'b1;
    tick(1); check_state("heat_entry", 18, 1, 0);
    tick(3); check("heat_c3", int'(temperature), 18);
    tick(1); check_state("heat_c4", 19, 1, 0);
    tick(16); check_state("heat_c20", 23, 1, 0);

    // Heating saturates at 31
    load = 1'b1; load_value = 5'd30; tick(1); load = 1'b0;
    check_state("heat_load30", 30, 1, 0);
    tick(4); check("heat_sat_31", int'(temperature), 31);
    tick(4); check("heat_sat_hold", int'(temperature), 31);

    // Cooling saturates at 0
    heating = 1'b0; load = 1'b1; load_value = 5'd2; tick(1); load = 1'b0;
    check_state("cool_load2", 2, 0, 0);
    cooling = 1'b1;
    tick(1); check_state("cool_entry", 2, 2, 0);
    tick(4); check("cool_c4", int'(temperature), 1);
    tick(4); check("cool_c8", int'(temperature), 0);
    tick(8); check_state("cool_c16", 0, 2, 0);

    // Fault latch, freeze, blocked clear, then clear into HEAT
    cooling = 1'b0; load = 1'b1; load_value = 5'd20; tick(1); load = 1'b0;
    heating = 1'b1; cooling = 1'b1;
    tick(1); check_state("fault_entry", 20, 3, 1);
    cooling = 1'b0;
    tick(30); check_state("fault_frozen", 20, 3, 1);
    cooling = 1'b1; fault_clr = 1'b1;
    tick(1); check_state("fault_clr_both", 20, 3, 1);
    cooling = 1'b0;
    tick(1); check_state("fault_cleared", 20, 1, 0);
    fault_clr = 1'b0;
    tick(3); check("post_clr_c3", int'(temperature), 20);
    tick(1); check("post_clr_c4", int'(temperature), 21);

    // Load together with both commands: FAULT with loaded temperature
    load = 1'b1; load_value = 5'd9; cooling = 1'b1;
    tick(1); check_state("load_fault", 9, 3, 1);
    load = 1'b0; heating = 1'b0; cooling = 1'b0; fault_clr = 1'b1;
    tick(1); check_state("clr_to_idle", 9, 0, 0);
    fault_clr = 1'b0;

    // Reset mid-ramp discards the partial count
    heating = 1'b1;
    tick(1); check("mid_entry_mode", int'(mode), 1);
    tick(2);
    #2 rst_n = 1'b0;
    #1 check_state("mid_reset", 18, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(1); check_state("rst_heat_entry", 18, 1, 0);
    tick(3); check("rst_heat_c3", int'(temperature), 18);
    tick(1); check("rst_heat_c4", int'(temperature), 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
